// File: rtl/mvm_job_sequencer.sv
// mvm_job_sequencer: host-side job controller for one mvm matrix-vector engine.
//
// Jobs arrive as a command handshake followed by a gap-tolerant operand stream
// (K*K row-major matrix words, then K vector words). Operands are staged locally
// and replayed to the engine as gap-free load bursts, the engine is started, its
// K result words are captured and then returned on a valid/ready stream.
//
// Optional feature macro: MVMSEQ_MATRIX_REUSE_EN
//   defined   : cmd_mat=0 jobs reuse the engine-resident matrix (once one is loaded)
//   undefined : cmd_mat is ignored and every job carries a full matrix
//
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_mat/cmd_ready        job command handshake
//   in_valid/in_data/in_ready          operand word stream
//   out_valid/out_data/out_ready       result word stream
//   mvm_loadMatrix/mvm_loadVector/mvm_start/mvm_data_in   engine controls (registered)
//   mvm_done/mvm_data_out              engine results
//   busy                               high whenever not idle
module mvm_job_sequencer #(
  parameter int unsigned K = 4,
  parameter int unsigned B = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic             cmd_mat,
  output logic             cmd_ready,
  input  logic             in_valid,
  input  logic [B-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [2*B-1:0]   out_data,
  input  logic             out_ready,
  output logic             mvm_loadMatrix,
  output logic             mvm_loadVector,
  output logic             mvm_start,
  output logic [B-1:0]     mvm_data_in,
  input  logic             mvm_done,
  input  logic [2*B-1:0]   mvm_data_out,
  output logic             busy
);

  localparam int unsigned NM = K * K;
  localparam int unsigned NW = $clog2(NM);
  localparam int unsigned KW = $clog2(K);
  localparam logic [NW-1:0] LastM = NW'(NM - 1);
  localparam logic [NW-1:0] LastV = NW'(K - 1);

  typedef enum logic [3:0] {
    StIdle, StFillM, StBurstM, StFillV, StBurstV, StStart, StWait, StCapt, StDrain
  } state_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic            live_q;
  logic            lm_q, lm_d, lv_q, lv_d, st_q, st_d;
  logic [B-1:0]    din_q, din_d;
  logic [B-1:0]    stage_q [NM];
  logic [2*B-1:0]  res_q [K];
  logic            cmd_ok, want_mat;

`ifdef MVMSEQ_MATRIX_REUSE_EN
  logic loaded_q;

  // A vector-only job is only meaningful once the engine holds a matrix.
  assign cmd_ok   = cmd_mat | loaded_q;
  assign want_mat = cmd_mat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loaded_q <= 1'b0;
    end else if (state_q == StBurstM) begin
      loaded_q <= 1'b1;
    end
  end
`else
  assign cmd_ok   = 1'b1;
  assign want_mat = 1'b1;
`endif

  // live_q keeps cmd_ready low while reset is asserted even though state is idle.
  assign cmd_ready      = live_q & (state_q == StIdle) & cmd_ok;
  assign in_ready       = (state_q == StFillM) | (state_q == StFillV);
  assign out_valid      = (state_q == StDrain);
  assign out_data       = out_valid ? res_q[cnt_q[KW-1:0]] : '0;
  assign busy           = (state_q != StIdle);
  assign mvm_loadMatrix = lm_q;
  assign mvm_loadVector = lv_q;
  assign mvm_start      = st_q;
  assign mvm_data_in    = din_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lm_d    = 1'b0;
    lv_d    = 1'b0;
    st_d    = 1'b0;
    din_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          cnt_d   = '0;
          state_d = want_mat ? StFillM : StFillV;
        end
      end
      StFillM: begin
        if (in_valid) begin
          if (cnt_q == LastM) begin
            cnt_d   = '0;
            lm_d    = 1'b1;
            state_d = StBurstM;
          end else begin
            cnt_d = cnt_q + NW'(1);
          end
        end
      end
      StBurstM: begin
        // Strobe went out on entry; words follow back-to-back one cycle later.
        din_d = stage_q[cnt_q];
        if (cnt_q == LastM) begin
          cnt_d   = '0;
          state_d = StFillV;
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      StFillV: begin
        if (in_valid) begin
          if (cnt_q == LastV) begin
            cnt_d   = '0;
            lv_d    = 1'b1;
            state_d = StBurstV;
          end else begin
            cnt_d = cnt_q + NW'(1);
          end
        end
      end
      StBurstV: begin
        din_d = stage_q[cnt_q];
        if (cnt_q == LastV) begin
          cnt_d   = '0;
          state_d = StStart;
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      StStart: begin
        st_d    = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (mvm_done) begin
          cnt_d   = NW'(1);
          state_d = StCapt;
        end
      end
      StCapt: begin
        // Remaining result words stream in on consecutive cycles after done.
        if (cnt_q == LastV) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (cnt_q == LastV) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + NW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      live_q  <= 1'b0;
      lm_q    <= 1'b0;
      lv_q    <= 1'b0;
      st_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      lm_q    <= lm_d;
      lv_q    <= lv_d;
      st_q    <= st_d;
      din_q   <= din_d;
    end
  end

  // Data buffers carry no reset; their contents are only read after being written.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      stage_q[cnt_q] <= in_data;
    end
    if (state_q == StWait && mvm_done) begin
      res_q[0] <= mvm_data_out;
    end else if (state_q == StCapt) begin
      res_q[cnt_q[KW-1:0]] <= mvm_data_out;
    end
  end

endmodule
